// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU drive and response signals of the ALU sequencer
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
);
  logic              In_ReqValid;
  logic              Out_ReqReady;
  logic [CTRL_W-1:0] In_ReqOp;
  logic [DATA_W-1:0] In_ReqA;
  logic [DATA_W-1:0] In_ReqB;
  logic [DATA_W-1:0] Out_A;
  logic [DATA_W-1:0] Out_B;
  logic [CTRL_W-1:0] Out_ALUCtrl;
  logic [DATA_W-1:0] In_ALUResult;
  logic              In_Zero;
  logic              Out_RspValid;
  logic              In_RspReady;
  logic [DATA_W-1:0] Out_RspResult;
  logic              Out_RspZero;
  logic              Out_RspErr;
  logic              Out_FlagZ;
  logic              Out_FlagN;
  logic [15:0]       Out_OpCount;

  modport slave (
    input  In_ReqValid, In_ReqOp, In_ReqA, In_ReqB, In_ALUResult, In_Zero, In_RspReady,
    output Out_ReqReady, Out_A, Out_B, Out_ALUCtrl, Out_RspValid, Out_RspResult,
           Out_RspZero, Out_RspErr, Out_FlagZ, Out_FlagN, Out_OpCount
  );

  modport master (
    output In_ReqValid, In_ReqOp, In_ReqA, In_ReqB, In_ALUResult, In_Zero, In_RspReady,
    input  Out_ReqReady, Out_A, Out_B, Out_ALUCtrl, Out_RspValid, Out_RspResult,
           Out_RspZero, Out_RspErr, Out_FlagZ, Out_FlagN, Out_OpCount
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response front end driving a combinational ALU
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
) (
  input logic          CLK,
  input logic          Reset,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              zero_q, zero_d, err_q, err_d;
  logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic [15:0]       op_count_q, op_count_d;
  logic              accept;
  logic              illegal;

  assign accept  = bus.In_ReqValid && (state_q == S_IDLE);
  assign illegal = (bus.In_ReqOp == {CTRL_W{1'b1}}) ||
                   ((bus.In_ReqOp == CTRL_W'(9)) && (bus.In_ReqB == '0));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '1;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      op_count_q <= op_count_d;
    end
  end

  // Rejected requests skip ISSUE entirely so the ALU never sees them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = illegal ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (bus.In_RspReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    err_d      = err_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    op_count_d = op_count_q;
    if (accept && !illegal) begin
      a_d    = bus.In_ReqA;
      b_d    = bus.In_ReqB;
      ctrl_d = bus.In_ReqOp;
    end
    if (accept && illegal) begin
      result_d = '0;
      zero_d   = 1'b0;
      err_d    = 1'b1;
    end
    if (state_q == S_ISSUE) begin
      result_d   = bus.In_ALUResult;
      zero_d     = bus.In_Zero;
      err_d      = 1'b0;
      flag_z_d   = bus.In_Zero;
      flag_n_d   = bus.In_ALUResult[DATA_W-1];
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_comb begin
    bus.Out_ReqReady = (state_q == S_IDLE);
    bus.Out_RspValid = (state_q == S_RESP);
  end

  assign bus.Out_A         = a_q;
  assign bus.Out_B         = b_q;
  assign bus.Out_ALUCtrl   = ctrl_q;
  assign bus.Out_RspResult = result_q;
  assign bus.Out_RspZero   = zero_q;
  assign bus.Out_RspErr    = err_q;
  assign bus.Out_FlagZ     = flag_z_q;
  assign bus.Out_FlagN     = flag_n_q;
  assign bus.Out_OpCount   = op_count_q;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request/response front end that drives the combinational ALU. It accepts one operation request (opcode plus two operands) over a valid/ready handshake and presents the opcode and operands on the ALU input ports from registers. It captures the ALU result and zero flag one cycle later and returns them over a second valid/ready handshake. It also screens out illegal and divide-by-zero requests, keeps sticky condition flags and counts completed operations; it sits between the datapath control unit and the ALU.

## Interface
- DATA_W, 16, operand/result width; must match the ALU.
- CTRL_W, 4, opcode width; must match the ALU control input.
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In_ReqValid  input  1  request present.
- Out_ReqReady  output  1  sequencer can accept a request.
- In_ReqOp  input  CTRL_W  opcode, same encoding as the ALU (0000 ADD … 1110 pass-B; 1111 illegal).
- In_ReqA  input  DATA_W  operand A.
- In_ReqB  input  DATA_W  operand B.
- Out_A  output  DATA_W  ALU operand A (registered).
- Out_B  output  DATA_W  ALU operand B (registered).
- Out_ALUCtrl  output  CTRL_W  ALU control (registered).
- In_ALUResult  input  DATA_W  ALU result.
- In_Zero  input  1  ALU zero flag.
- Out_RspValid  output  1  response present.
- In_RspReady  input  1  consumer takes the response.
- Out_RspResult  output  DATA_W  captured result.
- Out_RspZero  output  1  captured zero flag.
- Out_RspErr  output  1  request was rejected (illegal opcode or divide by zero).
- Out_FlagZ  output  1  zero flag of the last successful operation.
- Out_FlagN  output  1  sign (MSB) of the last successful operation's result.
- Out_OpCount  output  16  count of successful operations, wraps 0xFFFF→0x0000.

## Operation
- States:
  - IDLE: Out_ReqReady = 1.
  - ISSUE: ALU is driven.
  - RESP: Out_RspValid = 1.
- Out_ReqReady is high only in IDLE. Out_RspValid is high only in RESP.
- IDLE, request accepted (In_ReqValid && Out_ReqReady):
  - Register In_ReqOp, In_ReqA and In_ReqB into Out_ALUCtrl, Out_A and Out_B.
  - Go to ISSUE.
- IDLE, accepted request is illegal:
  - Illegal means opcode 1111, or opcode 1001 (DIV) with In_ReqB == 0.
  - Do not go to ISSUE. Go straight to RESP with Out_RspErr = 1, Out_RspResult = 0, Out_RspZero = 0.
  - Out_ALUCtrl, Out_A and Out_B are left unchanged.
  - Flags and counter are unchanged.
- ISSUE: one cycle. At its closing edge:
  - Capture In_ALUResult into Out_RspResult and In_Zero into Out_RspZero; set Out_RspErr = 0.
  - Set Out_FlagZ = In_Zero and Out_FlagN = In_ALUResult[DATA_W-1].
  - Increment Out_OpCount.
  - Go to RESP.
- RESP:
  - Response outputs hold stable while In_RspReady = 0.
  - On the edge where In_RspReady = 1, go to IDLE.
- Out_A, Out_B and Out_ALUCtrl hold their last issued values outside ISSUE. The ALU result is not consumed outside ISSUE.
- Request fields are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset (asynchronous, effective immediately):
  - state IDLE
  - Out_ReqReady = 1, Out_RspValid = 0
  - Out_A = 0, Out_B = 0, Out_ALUCtrl = 4'b1111 (ALU outputs 0)
  - Out_RspResult = 0, Out_RspZero = 0, Out_RspErr = 0
  - Out_FlagZ = 0, Out_FlagN = 0, Out_OpCount = 0
- Legal request accepted at edge k:
  - ISSUE during cycle k→k+1.
  - Out_RspValid rises after edge k+1.
- Illegal request accepted at edge k: Out_RspValid rises after edge k.
- Throughput: one legal operation per 3 cycles at best (accept, issue, response handshake). A new request cannot be accepted in the same cycle a response is taken.
- In_RspReady held high in RESP: exactly one cycle in RESP.
- Reset asserted in ISSUE or RESP:
  - The in-flight operation is discarded and no response is produced.
  - If reset lands on the ISSUE capture edge, the counter does not increment.
- In_ReqValid in ISSUE or RESP is ignored (not accepted) until IDLE.

## Test plan
- Reset then ADD: reset; request op 0000, A=0x0003, B=0x0004, RspReady=1 → RspValid two cycles after accept; Result 0x0007, Zero 0, Err 0; FlagN 0; OpCount 1.
- SUB to zero plus backpressure: op 0001, A=B=0x1234; RspReady low 5 cycles → Result 0x0000, Zero 1, held stable 5 cycles; ReqReady low throughout; FlagZ 1.
- Negative result: op 0001, A=0x0001, B=0x0002 → Result 0xFFFF, FlagN 1, FlagZ 0.
- Illegal requests:
  - op 1001, B=0 → RspValid one cycle after accept; Err 1; Result 0; Out_ALUCtrl unchanged; OpCount and flags unchanged.
  - op 1111 → same behaviour.
- Counter wrap: preload via 65535 back-to-back legal ops (or force), one more op → OpCount 0x0000.
- Reset mid-operation: assert Reset during ISSUE of op 1000, A=3, B=5 → RspValid never asserts; outputs return to reset values immediately; the next request completes normally.
